// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO controller with internal register storage.
//   Generic width/depth, occupancy count, almost-full/almost-empty thresholds,
//   sticky overflow/underflow flags and a synchronous flush (clear).
//   All flags are registered and reflect post-edge state.
// Optional feature macro: SYNC_FIFO_FWFT_EN
//   undefined : rdata registered, valid one cycle after an accepted rinc
//   defined   : first-word fall-through, rdata shows mem[rptr] while not empty
// Ports:
//   wclk, wrst_n         clock, async active-low reset
//   clear                synchronous flush (priority over winc/rinc)
//   winc, wdata          write request / data
//   rinc, rdata          read request / data
//   wfull, rempty        full / empty
//   walmost_full         count >= AF_THRESH
//   ralmost_empty        count <= AE_THRESH
//   count                occupancy 0..DEPTH
//   overflow, underflow  sticky write-while-full / read-while-empty
module sync_fifo_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned AF_THRESH  = 14,
  parameter int unsigned AE_THRESH  = 2
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  clear,
  input  logic                  winc,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rinc,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  walmost_full,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned PW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW-1:0]         r_count;
  logic                  r_wfull;
  logic                  r_rempty;
  logic                  r_afull;
  logic                  r_aempty;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic [PW-1:0]         w_wptr_nxt;
  logic [PW-1:0]         w_rptr_nxt;
  logic [PW-1:0]         w_count_nxt;
  logic [PW-1:0]         w_ptr_xor;

  // Accept decisions and next pointer/count values
  always_comb begin
    w_wr_acc    = winc & ~r_wfull;
    w_rd_acc    = rinc & ~r_rempty;
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    if (w_wr_acc) w_wptr_nxt = r_wptr + PW'(1);
    if (w_rd_acc) w_rptr_nxt = r_rptr + PW'(1);
    if (w_wr_acc && !w_rd_acc) w_count_nxt = r_count + PW'(1);
    if (w_rd_acc && !w_wr_acc) w_count_nxt = r_count - PW'(1);
    // Full when pointers differ only in the wrap bit
    w_ptr_xor   = w_wptr_nxt ^ w_rptr_nxt;
  end

  // Pointers, count, flags and sticky errors
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_rempty    <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clear) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_wfull     <= 1'b0;
      r_rempty    <= 1'b1;
      r_afull     <= 1'b0;
      r_aempty    <= 1'b1;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr   <= w_wptr_nxt;
      r_rptr   <= w_rptr_nxt;
      r_count  <= w_count_nxt;
      r_wfull  <= (w_ptr_xor == {1'b1, {ADDR_WIDTH{1'b0}}});
      r_rempty <= (w_ptr_xor == '0);
      r_afull  <= (w_count_nxt >= PW'(AF_THRESH));
      r_aempty <= (w_count_nxt <= PW'(AE_THRESH));
      if (winc && r_wfull)  r_overflow  <= 1'b1;
      if (rinc && r_rempty) r_underflow <= 1'b1;
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge wclk) begin
    if (w_wr_acc && !clear) r_mem[r_wptr[ADDR_WIDTH-1:0]] <= wdata;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word presented directly from storage; zero while empty
  assign rdata = r_rempty ? '0 : r_mem[r_rptr[ADDR_WIDTH-1:0]];
`else
  logic [DATA_WIDTH-1:0] r_rdata;

  // Registered read; holds across clear and idle cycles
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n)                 r_rdata <= '0;
    else if (w_rd_acc && !clear) r_rdata <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
  end

  assign rdata = r_rdata;
`endif

  assign wfull         = r_wfull;
  assign rempty        = r_rempty;
  assign walmost_full  = r_afull;
  assign ralmost_empty = r_aempty;
  assign count         = r_count;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl
// (default parameters: 8-bit data, depth 16, AF=14, AE=2).
module tb_sync_fifo_ctrl;

  logic       wclk;
  logic       wrst_n;
  logic       clear;
  logic       winc;
  logic [7:0] wdata;
  logic       rinc;
  logic [7:0] rdata;
  logic       wfull;
  logic       rempty;
  logic       walmost_full;
  logic       ralmost_empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  logic [7:0] q[$];
  bit         m_ov = 1'b0;
  bit         m_un = 1'b0;
  bit         up;

  sync_fifo_ctrl #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(4),
    .AF_THRESH (14),
    .AE_THRESH (2)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .clear        (clear),
    .winc         (winc),
    .wdata        (wdata),
    .rinc         (rinc),
    .rdata        (rdata),
    .wfull        (wfull),
    .rempty       (rempty),
    .walmost_full (walmost_full),
    .ralmost_empty(ralmost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Compare every flag against the queue-based model
  task automatic check_flags(input string ctx);
    int unsigned n;
    n = q.size();
    check({ctx, "_count"},  32'(count),         32'(n));
    check({ctx, "_rempty"}, 32'(rempty),        32'(n == 0));
    check({ctx, "_wfull"},  32'(wfull),         32'(n == 16));
    check({ctx, "_afull"},  32'(walmost_full),  32'(n >= 14));
    check({ctx, "_aempty"}, 32'(ralmost_empty), 32'(n <= 2));
    check({ctx, "_ovf"},    32'(overflow),      32'(m_ov));
    check({ctx, "_unf"},    32'(underflow),     32'(m_un));
  endtask

  // One clock of traffic, with the model updated in step
  task automatic cycle(input bit w, input logic [7:0] d, input bit r);
    bit         wa;
    bit         ra;
    logic [7:0] exp_rd;
    wa     = w && (q.size() < 16);
    ra     = r && (q.size() > 0);
    exp_rd = 8'h00;
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() > 0) check("fwft_head", 32'(rdata), 32'(q[0]));
`endif
    if (w && q.size() == 16) m_ov = 1'b1;
    if (r && q.size() == 0)  m_un = 1'b1;
    winc  = w;
    wdata = d;
    rinc  = r;
    tick();
    winc = 1'b0;
    rinc = 1'b0;
    if (ra) exp_rd = q.pop_front();
    if (wa) q.push_back(d);
`ifdef SYNC_FIFO_FWFT_EN
    if (q.size() == 0) check("fwft_empty_rdata", 32'(rdata), 32'h0);
`else
    if (ra) check("rdata", 32'(rdata), 32'(exp_rd));
`endif
    check_flags("cyc");
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    check_flags("clear");
  endtask

  initial begin
    wrst_n = 1'b0;
    clear  = 1'b0;
    winc   = 1'b0;
    rinc   = 1'b0;
    wdata  = 8'h00;

    // Power-on reset values
    repeat (2) tick();
    check_flags("por");
    check("por_rdata", 32'(rdata), 32'h0);
    wrst_n = 1'b1;
    tick();

    // Reset mid-stream at count=5
    for (int i = 0; i < 7; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0);
    for (int i = 0; i < 2; i++) cycle(1'b0, 8'h00, 1'b1);
    check("mid_count5", 32'(count), 32'd5);
    wrst_n = 1'b0;
    #1;
    q.delete();
    check_flags("midrst");
    check("midrst_rdata", 32'(rdata), 32'h0);
    tick();
    wrst_n = 1'b1;
    tick();
    check_flags("post_rst");

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), 1'b0);
    check("fill_count", 32'(count), 32'd16);
    check("fill_wfull", 32'(wfull), 32'd1);

    // Overflow: 0xAA rejected
    cycle(1'b1, 8'hAA, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);

    // Drain; data order checked inside cycle()
    for (int i = 0; i < 16; i++) cycle(1'b0, 8'h00, 1'b1);
    check("drain_rempty", 32'(rempty), 32'd1);

    // Underflow then clear
    cycle(1'b0, 8'h00, 1'b1);
    check("unf_flag", 32'(underflow), 32'd1);
    do_clear();
    check("clr_ovf", 32'(overflow), 32'd0);
    check("clr_unf", 32'(underflow), 32'd0);
    check("clr_count", 32'(count), 32'd0);

    // Simultaneous read/write at count=8
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b1);
    check("sim8_count", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous at full: read wins, write rejected
    do_clear();
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
    cycle(1'b1, 8'hBB, 1'b1);
    check("simfull_count", 32'(count), 32'd15);
    check("simfull_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 15; i++) cycle(1'b0, 8'h00, 1'b1);

    // Simultaneous at empty: write wins, read rejected
    do_clear();
    cycle(1'b1, 8'hCC, 1'b1);
    check("simempty_count", 32'(count), 32'd1);
    check("simempty_unf", 32'(underflow), 32'd1);
    cycle(1'b0, 8'h00, 1'b1);
    do_clear();

    // Wrap-around with count oscillating 3..6
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0);
    up = 1'b1;
    for (int i = 0; i < 140; i++) begin
      if (up) cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      else    cycle(1'b0, 8'h00, 1'b1);
      if (q.size() == 6) up = 1'b0;
      if (q.size() == 3) up = 1'b1;
    end
    while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1);

`ifdef SYNC_FIFO_FWFT_EN
    // First-word fall-through: data visible with no rinc
    do_clear();
    winc  = 1'b1;
    wdata = 8'h5A;
    tick();
    winc = 1'b0;
    check("fwft_5a", 32'(rdata), 32'h5A);
    check("fwft_not_empty", 32'(rempty), 32'd0);
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    check("fwft_pop_empty", 32'(rempty), 32'd1);
    check("fwft_pop_rdata", 32'(rdata), 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
